timer_phase_sequencer: RTL

- Controller that sequences a fixed list of timed phases (e.g. soak/wash/spin) with non-recycling phase counters.
- Each phase counts prescaled ticks up to a programmed duration, pulses completion, then advances to the next phase; after the last phase it holds DONE and does not wrap.
- Sits between the user-control inputs (start/pause/cancel) and the timer prescaler; its outputs drive the actuator and display logic.

---
 rtl/timer_seq_pkg.sv | 32 +++
 rtl/phase_tick_counter.sv | 29 ++
 rtl/timer_phase_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/timer_seq_pkg.sv
// Shared types and helpers for the timed phase sequencer.
package timer_seq_pkg;

    localparam int unsigned N_PHASES = 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        RUN    = ST_RUN,
        PAUSED = ST_PAUSED,
        DONE   = ST_DONE
    } state_e;

    // A programmed duration of zero still occupies one tick.
    function automatic int unsigned phase_duration(input int unsigned idx,
                                                   input int unsigned t0,
                                                   input int unsigned t1,
                                                   input int unsigned t2);
        int unsigned d;
        case (idx)
            0:       d = t0;
            1:       d = t1;
            default: d = t2;
        endcase
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/phase_tick_counter.sv
// Per-phase tick counter: counts enabled ticks up to limit-1, then returns to zero.
module phase_tick_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic             restart,
    input  logic [CNT_W:0]   limit,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    logic [CNT_W:0] last;

    assign last     = limit - 1'b1;
    assign terminal = en && ({1'b0, count} == last);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (restart || terminal) begin
            count <= '0;
        end else if (en && ({1'b0, count} < last)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/timer_phase_sequencer.sv
// Sequences three timed phases on prescaler ticks; holds DONE after the last phase.
module timer_phase_sequencer
    import timer_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned T0    = 3,
    parameter int unsigned T1    = 5,
    parameter int unsigned T2    = 2
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             tick,
    input  logic             start,
    input  logic             pause,
    input  logic             cancel,
    output logic             busy,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] count,
    output logic             phase_done,
    output logic             done
);

    localparam int unsigned D0 = phase_duration(0, T0, T1, T2);
    localparam int unsigned D1 = phase_duration(1, T0, T1, T2);
    localparam int unsigned D2 = phase_duration(2, T0, T1, T2);

    if (D0 > (1 << CNT_W) || D1 > (1 << CNT_W) || D2 > (1 << CNT_W)) begin : g_bad_duration
        $fatal(1, "timer_phase_sequencer: phase duration does not fit CNT_W");
    end

    state_e         state;
    logic [CNT_W:0] limit;
    logic           en;
    logic           restart;
    logic           terminal;
    logic           can_start;

    always_comb begin
        limit = (CNT_W + 1)'(D2);
        case (phase)
            2'd0:    limit = (CNT_W + 1)'(D0);
            2'd1:    limit = (CNT_W + 1)'(D1);
            default: limit = (CNT_W + 1)'(D2);
        endcase
    end

    // Ticks count only in RUN with neither cancel nor pause competing.
    assign can_start = (state == IDLE) || (state == DONE);
    assign en        = (state == RUN) && tick && !pause && !cancel;
    assign restart   = cancel || (can_start && start);

    phase_tick_counter #(.CNT_W(CNT_W)) u_counter (
        .clock    (clock),
        .clear    (clear),
        .en       (en),
        .restart  (restart),
        .limit    (limit),
        .count    (count),
        .terminal (terminal)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state      <= IDLE;
            phase      <= '0;
            phase_done <= 1'b0;
        end else begin
            phase_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!cancel && start) begin
                        state <= RUN;
                        phase <= '0;
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state <= IDLE;
                        phase <= '0;
                    end else if (pause) begin
                        state <= PAUSED;
                    end else if (terminal) begin
                        phase_done <= 1'b1;
                        if (phase == 2'(N_PHASES - 1)) begin
                            state <= DONE;
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (cancel) begin
                        state <= IDLE;
                        phase <= '0;
                    end else if (!pause) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    if (cancel) begin
                        state <= IDLE;
                        phase <= '0;
                    end else if (start) begin
                        state <= RUN;
                        phase <= '0;
                    end
                end
            endcase
        end
    end

    assign busy = (state == RUN) || (state == PAUSED);
    assign done = (state == DONE);

endmodule
